// File: rtl/pll40_pkg.sv
// pll40_pkg: shared constants and helpers for the pll40_core_model behavioural PLL.
//   ACC_W  - width of the NCO phase accumulator (holds values up to 2*D-1 <= 2047)
//   LOCK_W - width of the lock counter
//   calc_d       - reference-side modulus D = (DIVR+1) << DIVQ
//   calc_n       - feedback increment N = DIVF+1
//   params_legal - elaboration legality check for the divider/lock settings
package pll40_pkg;

    localparam int ACC_W  = 11;
    localparam int LOCK_W = 16;

    function automatic logic [ACC_W-1:0] calc_d(input logic [3:0] divr, input logic [2:0] divq);
        logic [ACC_W-1:0] r;
        r = ACC_W'(divr) + ACC_W'(1);
        return r << divq;
    endfunction

    function automatic logic [ACC_W-1:0] calc_n(input logic [6:0] divf);
        return ACC_W'(divf) + ACC_W'(1);
    endfunction

    // DIVQ is checked first: D would overflow ACC_W for DIVQ=7.
    function automatic bit params_legal(input logic [3:0] divr, input logic [6:0] divf,
                                        input logic [2:0] divq, input int lock_cycles);
        if (divq > 3'd6) return 1'b0;
        if (calc_n(divf) > calc_d(divr, divq)) return 1'b0;
        if (lock_cycles < 1 || lock_cycles > 65535) return 1'b0;
        return 1'b1;
    endfunction

endpackage

// File: rtl/pll40_if.sv
// pll40_if: groups the PLL control/status signals of pll40_core_model.
//   BYPASS          - 1 = outputs follow REFERENCECLK directly
//   PLLOUTCORE      - synthesised clock
//   PLLOUTGLOBAL    - copy of PLLOUTCORE
//   LOCK            - lock indicator
//   ACC_DBG, EN_DBG - NCO phase accumulator and pass-enable register (observation only)
//   LATCHINPUTVALUE - output freeze request, present only when PLL40_ICEGATE_EN is defined
// Modports: slave = the PLL model, master = whoever drives BYPASS and consumes the clocks.
interface pll40_if;
    import pll40_pkg::*;

    logic             BYPASS;
    logic             PLLOUTCORE;
    logic             PLLOUTGLOBAL;
    logic             LOCK;
    logic [ACC_W-1:0] ACC_DBG;
    logic             EN_DBG;
`ifdef PLL40_ICEGATE_EN
    logic             LATCHINPUTVALUE;

    modport slave  (input  BYPASS, LATCHINPUTVALUE,
                    output PLLOUTCORE, PLLOUTGLOBAL, LOCK, ACC_DBG, EN_DBG);
    modport master (output BYPASS, LATCHINPUTVALUE,
                    input  PLLOUTCORE, PLLOUTGLOBAL, LOCK, ACC_DBG, EN_DBG);
`else
    modport slave  (input  BYPASS,
                    output PLLOUTCORE, PLLOUTGLOBAL, LOCK, ACC_DBG, EN_DBG);
    modport master (output BYPASS,
                    input  PLLOUTCORE, PLLOUTGLOBAL, LOCK, ACC_DBG, EN_DBG);
`endif
endinterface

// File: rtl/pll40_clk_gate.sv
// pll40_clk_gate: ICG-style glitch-free clock gate.
//   clk_i  - clock to be gated
//   en_i   - pass enable, sampled while clk_i is low
//   gclk_o - clk_i AND latched enable
// The latch is closed for the whole high phase, so en_i may change right after
// the rising edge without chopping the pulse currently on gclk_o.
module pll40_clk_gate (
    input  logic clk_i,
    input  logic en_i,
    output logic gclk_o
);

    logic en_lat_q;

    always_latch begin
        if (!clk_i) en_lat_q <= en_i;
    end

    assign gclk_o = clk_i & en_lat_q;

endmodule

// File: rtl/pll40_core_model.sv
// pll40_core_model: cycle-accurate behavioural model of the iCE40 SB_PLL40_CORE.
// Produces f_out = f_ref*(DIVF+1)/((DIVR+1)*2^DIVQ) by swallowing REFERENCECLK
// pulses under control of a phase-accumulator NCO.
// Ports:
//   REFERENCECLK - reference clock, the only clock
//   RESET        - synchronous, active-high reset
//   pll          - pll40_if.slave: BYPASS in; PLLOUTCORE, PLLOUTGLOBAL, LOCK,
//                  ACC_DBG, EN_DBG out; LATCHINPUTVALUE in with PLL40_ICEGATE_EN
// Optional feature macro: PLL40_ICEGATE_EN (adds LATCHINPUTVALUE output freeze,
// active when ENABLE_ICEGATE=1). Without it ENABLE_ICEGATE has no effect.
module pll40_core_model
    import pll40_pkg::*;
#(
    parameter logic [3:0] DIVR           = 4'd0,
    parameter logic [6:0] DIVF           = 7'd9,
    parameter logic [2:0] DIVQ           = 3'd4,
    parameter logic [2:0] FILTER_RANGE   = 3'b001,
    parameter             FEEDBACK_PATH  = "SIMPLE",
    parameter             PLLOUT_SELECT  = "GENCLK",
    parameter logic       ENABLE_ICEGATE = 1'b0,
    parameter int         LOCK_CYCLES    = 64
) (
    input  logic     REFERENCECLK,
    input  logic     RESET,
    pll40_if.slave   pll
);

    localparam logic [ACC_W-1:0]  D        = calc_d(DIVR, DIVQ);
    localparam logic [ACC_W-1:0]  N        = calc_n(DIVF);
    localparam logic [LOCK_W-1:0] LOCK_TGT = LOCK_W'(LOCK_CYCLES);

    generate
        if (!params_legal(DIVR, DIVF, DIVQ, LOCK_CYCLES)) begin : g_bad_divider
            $error("pll40_core_model: illegal DIVR/DIVF/DIVQ/LOCK_CYCLES combination");
        end
        if (FEEDBACK_PATH != "SIMPLE") begin : g_bad_feedback
            $error("pll40_core_model: only FEEDBACK_PATH=\"SIMPLE\" is supported");
        end
        if (PLLOUT_SELECT != "GENCLK") begin : g_bad_outsel
            $error("pll40_core_model: only PLLOUT_SELECT=\"GENCLK\" is supported");
        end
    endgenerate

    logic [ACC_W-1:0]  acc_q, acc_d, sum;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              lock_q, lock_d;
    logic              en_q, en_d;
    logic              freeze;
    logic              gate_en;
    logic              gclk;

    // The filter setting has no behavioural meaning in this model.
    logic unused_cfg;

`ifdef PLL40_ICEGATE_EN
    assign freeze     = ENABLE_ICEGATE & pll.LATCHINPUTVALUE;
    assign unused_cfg = ^FILTER_RANGE;
`else
    assign freeze     = 1'b0;
    assign unused_cfg = ^{FILTER_RANGE, ENABLE_ICEGATE};
`endif

    // NCO and lock counter next state. sum never exceeds 2*D-1, so it fits ACC_W.
    always_comb begin
        sum        = acc_q + N;
        acc_d      = acc_q;
        en_d       = 1'b0;
        lock_cnt_d = (lock_cnt_q == LOCK_TGT) ? lock_cnt_q : lock_cnt_q + LOCK_W'(1);
        lock_d     = (lock_cnt_d == LOCK_TGT);
        if (freeze) begin
            acc_d = acc_q;
            en_d  = 1'b0;
        end else if (sum >= D) begin
            acc_d = sum - D;
            en_d  = lock_d;
        end else begin
            acc_d = sum;
        end
    end

    always_ff @(posedge REFERENCECLK) begin
        if (RESET) begin
            acc_q      <= '0;
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
            en_q       <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
            en_q       <= en_d;
        end
    end

    // Masking with RESET/freeze before the latch keeps the output low in the
    // very cycle those take effect, instead of one pulse later.
    assign gate_en = en_q & ~RESET & ~freeze;

    pll40_clk_gate u_gate (
        .clk_i  (REFERENCECLK),
        .en_i   (gate_en),
        .gclk_o (gclk)
    );

    assign pll.PLLOUTCORE   = pll.BYPASS ? REFERENCECLK : gclk;
    assign pll.PLLOUTGLOBAL = pll.BYPASS ? REFERENCECLK : gclk;
    assign pll.LOCK         = lock_q;
    assign pll.ACC_DBG      = acc_q;
    assign pll.EN_DBG       = en_q;

endmodule

// File: tb/tb_pll40_core_model.sv
module tb_pll40_core_model;
    import pll40_pkg::*;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    pll40_if if0 ();
    pll40_if if1 ();
    pll40_if if2 ();

    // Defaults: N=10, D=16
    pll40_core_model #(.DIVR(4'd0), .DIVF(7'd9), .DIVQ(3'd4), .ENABLE_ICEGATE(1'b1),
                       .LOCK_CYCLES(4)) dut0 (.REFERENCECLK(clk), .RESET(rst), .pll(if0));
    // N=D=16
    pll40_core_model #(.DIVR(4'd0), .DIVF(7'd15), .DIVQ(3'd4), .ENABLE_ICEGATE(1'b0),
                       .LOCK_CYCLES(4)) dut1 (.REFERENCECLK(clk), .RESET(rst), .pll(if1));
    // N=1, D=64
    pll40_core_model #(.DIVR(4'd0), .DIVF(7'd0), .DIVQ(3'd6), .ENABLE_ICEGATE(1'b0),
                       .LOCK_CYCLES(4)) dut2 (.REFERENCECLK(clk), .RESET(rst), .pll(if2));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // One reference cycle: check the low phase, then stop 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        #1;
        chk("out_lo", 32'(if0.PLLOUTCORE), 32'd0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic        byp;
        logic [10:0] acc;
        logic        en;
        logic        lock;
        logic        out;
    } vec_t;

    vec_t vecs[22];

    typedef struct {
        logic [10:0] acc;
        logic        en;
        logic        out;
    } gate_vec_t;

    int c0, g0, c1, c2;

    initial begin
        // rst, byp, acc, en, lock, out during the high phase after the edge
        vecs[0]  = '{1'b0, 1'b0, 11'd10, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 11'd4,  1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 11'd14, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 11'd8,  1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 11'd2,  1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 11'd12, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 11'd6,  1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 11'd0,  1'b1, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 11'd10, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 11'd4,  1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 11'd14, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 11'd8,  1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 11'd0,  1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 11'd0,  1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b0, 11'd10, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 11'd4,  1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 11'd14, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 11'd8,  1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 11'd2,  1'b1, 1'b1, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 11'd12, 1'b0, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 11'd6,  1'b1, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 11'd0,  1'b1, 1'b1, 1'b1};

        total  = 0;
        passed = 0;
        rst    = 1'b1;
        if0.BYPASS = 1'b0;
        if1.BYPASS = 1'b0;
        if2.BYPASS = 1'b0;
`ifdef PLL40_ICEGATE_EN
        if0.LATCHINPUTVALUE = 1'b0;
        if1.LATCHINPUTVALUE = 1'b0;
        if2.LATCHINPUTVALUE = 1'b0;
`endif

        // Reset held for three cycles
        repeat (3) tick();
        chk("rst_acc",  32'(if0.ACC_DBG),    32'd0);
        chk("rst_en",   32'(if0.EN_DBG),     32'd0);
        chk("rst_lock", 32'(if0.LOCK),       32'd0);
        chk("rst_out",  32'(if0.PLLOUTCORE), 32'd0);
        chk("rst_lock1", 32'(if1.LOCK),      32'd0);
        chk("rst_lock2", 32'(if2.LOCK),      32'd0);

        // Lock, NCO pattern, bypass, mid-stream reset at acc=8, relock
        for (int i = 0; i < 22; i++) begin
            rst        = vecs[i].rst;
            if0.BYPASS = vecs[i].byp;
            tick();
            chk($sformatf("v%0d_acc", i),  32'(if0.ACC_DBG),      32'(vecs[i].acc));
            chk($sformatf("v%0d_en", i),   32'(if0.EN_DBG),       32'(vecs[i].en));
            chk($sformatf("v%0d_lock", i), 32'(if0.LOCK),         32'(vecs[i].lock));
            chk($sformatf("v%0d_out", i),  32'(if0.PLLOUTCORE),   32'(vecs[i].out));
            chk($sformatf("v%0d_glb", i),  32'(if0.PLLOUTGLOBAL), 32'(vecs[i].out));
        end

        // N == D: accumulator stays at zero and every cycle passes
        chk("nd_acc",  32'(if1.ACC_DBG), 32'd0);
        chk("nd_en",   32'(if1.EN_DBG),  32'd1);
        chk("nd_lock", 32'(if1.LOCK),    32'd1);
        chk("q6_lock", 32'(if2.LOCK),    32'd1);

        // Steady-state pulse counts over 1600 reference cycles
        c0 = 0; g0 = 0; c1 = 0; c2 = 0;
        for (int i = 0; i < 1600; i++) begin
            tick();
            if (if0.PLLOUTCORE)   c0++;
            if (if0.PLLOUTGLOBAL) g0++;
            if (if1.PLLOUTCORE)   c1++;
            if (if2.PLLOUTCORE)   c2++;
        end
        chk("cnt_default", 32'(c0), 32'd1000);
        chk("cnt_global",  32'(g0), 32'd1000);
        chk("cnt_n_eq_d",  32'(c1), 32'd1600);
        chk("cnt_divq6",   32'(c2), 32'd25);

`ifdef PLL40_ICEGATE_EN
        // Restart from phase 0, run 8 cycles to acc=0, then freeze for 5 cycles
        begin
            gate_vec_t post[4];
            post[0] = '{11'd10, 1'b0, 1'b0};
            post[1] = '{11'd4,  1'b1, 1'b0};
            post[2] = '{11'd14, 1'b0, 1'b1};
            post[3] = '{11'd8,  1'b1, 1'b0};
            rst = 1'b1;
            tick();
            rst = 1'b0;
            repeat (8) tick();
            chk("ig_start_acc", 32'(if0.ACC_DBG), 32'd0);
            chk("ig_start_en",  32'(if0.EN_DBG),  32'd1);
            if0.LATCHINPUTVALUE = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick();
                chk($sformatf("ig%0d_acc", i),  32'(if0.ACC_DBG),    32'd0);
                chk($sformatf("ig%0d_en", i),   32'(if0.EN_DBG),     32'd0);
                chk($sformatf("ig%0d_out", i),  32'(if0.PLLOUTCORE), 32'd0);
                chk($sformatf("ig%0d_lock", i), 32'(if0.LOCK),       32'd1);
            end
            if0.LATCHINPUTVALUE = 1'b0;
            for (int i = 0; i < 4; i++) begin
                tick();
                chk($sformatf("igr%0d_acc", i), 32'(if0.ACC_DBG),    32'(post[i].acc));
                chk($sformatf("igr%0d_en", i),  32'(if0.EN_DBG),     32'(post[i].en));
                chk($sformatf("igr%0d_out", i), 32'(if0.PLLOUTCORE), 32'(post[i].out));
            end
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pll40_core_model.md
Name: pll40_core_model

Overview:
- Cycle-accurate behavioural model of the iCE40 SB_PLL40_CORE primitive, used in place of the hard PLL in simulation and in non-iCE40 builds.
- Synthesises a lower, average-exact output frequency from REFERENCECLK by NCO-controlled pulse swallowing: f_out = f_ref·(DIVF+1)/((DIVR+1)·2^DIVQ).
- Feeds the VGA pixel clock; defaults give 16 MHz → 10 MHz.

Parameters:
- DIVR, 0, 4-bit reference divider; R = DIVR+1.
- DIVF, 9, 7-bit feedback divider; N = DIVF+1.
- DIVQ, 4, 3-bit output divider exponent, legal 0..6.
- FILTER_RANGE, 3'b001, accepted and ignored.
- FEEDBACK_PATH, "SIMPLE", only "SIMPLE" supported; any other value is an elaboration error.
- PLLOUT_SELECT, "GENCLK", only "GENCLK" supported.
- ENABLE_ICEGATE, 1'b0, enables output freeze (see Optional Feature).
- LOCK_CYCLES, 64, number of reference cycles after reset release before LOCK asserts; range 1..65535.

Ports:
- REFERENCECLK  in  1  reference clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- BYPASS  in  1  1 = PLLOUTCORE/PLLOUTGLOBAL driven directly from REFERENCECLK.
- PLLOUTCORE  out  1  synthesised clock.
- PLLOUTGLOBAL  out  1  identical copy of PLLOUTCORE.
- LOCK  out  1  high once the lock counter has reached LOCK_CYCLES.

Behaviour:
- Constants: D = R << DIVQ (11 bits, maximum 1024); N as above.
- Elaboration error if N > D (output above reference), DIVQ > 6, or LOCK_CYCLES = 0.
- State, all updated on posedge REFERENCECLK:
  - acc[10:0]: phase accumulator.
  - lock_cnt[15:0]: lock counter.
  - LOCK.
  - en: pass enable.
- RESET=1: acc=0, lock_cnt=0, LOCK=0, en=0; takes effect at the next posedge.
- Reset mid-operation: same as above; the output pulse stream restarts from phase 0 once RESET is released.
- Each non-reset cycle:
  - s = acc + N.
  - If s >= D: acc <= s-D and en <= LOCK_next. Otherwise acc <= s and en <= 0.
- Lock counter: lock_cnt saturates at LOCK_CYCLES; LOCK <= (lock_cnt_next == LOCK_CYCLES).
- Pass-enable latency: en set at posedge k passes the REFERENCECLK high phase of cycle k+1.
- Glitch-free gating:
  - en passes through a latch that is transparent while REFERENCECLK is low.
  - PLLOUTCORE = REFERENCECLK AND latched en.
- Before LOCK, or during RESET, PLLOUTCORE is held at 0.
- BYPASS=1: PLLOUTCORE = REFERENCECLK combinationally, regardless of RESET or LOCK. The NCO and lock counter keep running, so toggling BYPASS changes no state.
- Steady state: exactly N pulses pass per D reference cycles; the pattern repeats every D/gcd(N,D) cycles.
- N == D: every pulse passes (acc stays 0).

Optional Feature:
- Macro PLL40_ICEGATE_EN.
- When defined:
  - Adds input LATCHINPUTVALUE (1 bit).
  - If ENABLE_ICEGATE=1 and LATCHINPUTVALUE=1: en is forced 0 and acc is frozen, so the output is held low. The lock counter continues.
  - Release resumes from the frozen acc.
- When undefined: no LATCHINPUTVALUE port; ENABLE_ICEGATE is ignored.

Decomposition:
- Package pll40_pkg:
  - Width constants ACC_W=11, LOCK_W=16.
  - Functions calc_d(DIVR,DIVQ) and calc_n(DIVF).
  - Legality-check function.
- Sub-module pll40_clk_gate: negative-transparent latch plus AND, ICG-style; instantiated once.
- Top holds the NCO and lock logic.

Test Plan:
- Defaults (N=10, D=16), LOCK_CYCLES=4: hold RESET 3 cycles, release → LOCK rises at the 4th posedge after release; PLLOUTCORE stays 0 before it.
- Defaults, after lock → en pattern per 8-cycle window is 0,1,0,1,1,0,1,1 from acc=0 (acc 10,4,14,8,2,12,6,0); 1000 gated edges per 1600 reference cycles; PLLOUTGLOBAL == PLLOUTCORE.
- BYPASS=1 at any time, including during RESET → PLLOUTCORE mirrors REFERENCECLK edge-for-edge; clearing BYPASS resumes the NCO pattern with no lost phase.
- DIVF=15, DIVR=0, DIVQ=4 (N=D=16) → every reference pulse passes after lock; DIVF=0, DIVQ=6 → 1 pulse per 64 cycles.
- RESET asserted mid-stream at acc=8 → next cycle acc=0, LOCK=0, output 0; after release, relock in LOCK_CYCLES and the pattern restarts from phase 0.
- PLL40_ICEGATE_EN defined, ENABLE_ICEGATE=1, LATCHINPUTVALUE pulsed high for 5 cycles → no output pulses, acc unchanged; afterwards the pattern continues from the frozen phase.
